// File: rtl/controlador_buffer_rolhas_if.sv
// controlador_buffer_rolhas_if: request/grant and status bundle between the line control and the cork stock controller
interface controlador_buffer_rolhas_if;
    logic       enable;
    logic       req_consumo;
    logic       req_carga;
    logic [6:0] qtd_carga;
    logic [6:0] count;
    logic       gnt_consumo;
    logic       gnt_carga;
    logic       gnt_reposicao;
    logic       ro;
    logic       min_r;
    logic       sat;
    logic       falta;
    logic [1:0] estado;
    modport master (
        output enable, req_consumo, req_carga, qtd_carga,
        input  count, gnt_consumo, gnt_carga, gnt_reposicao, ro, min_r, sat, falta, estado
    );
    modport slave (
        input  enable, req_consumo, req_carga, qtd_carga,
        output count, gnt_consumo, gnt_carga, gnt_reposicao, ro, min_r, sat, falta, estado
    );
endinterface

// File: rtl/controlador_buffer_rolhas.sv
// controlador_buffer_rolhas: owns the cork stock register and arbitrates consume, operator load and automatic refill
module controlador_buffer_rolhas #(
    parameter int MAX_R    = 99,
    parameter int MIN_R    = 5,
    parameter int LOTE_R   = 20,
    parameter int ESPERA_R = 3
) (
    input logic clk,
    input logic clr,
    controlador_buffer_rolhas_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, CONSUMO = 2'b01, CARGA = 2'b10, REPOSICAO = 2'b11} estado_t;
    localparam int WW = ESPERA_R > 1 ? $clog2(ESPERA_R) : 1;
    estado_t estado, estado_nx;
    logic [WW-1:0] espera, espera_nx;
    logic [6:0] count, count_nx;
    logic [1:0] pend_consumo;
    logic pend_carga, prev_consumo, prev_carga;
    logic ed_consumo, ed_carga, ro, baixo, clip_carga, clip_lote;
    logic [7:0] soma_carga, soma_lote;
    // edges seen while halted are dropped, not deferred
    assign ed_consumo = bus.enable & bus.req_consumo & ~prev_consumo;
    assign ed_carga   = bus.enable & bus.req_carga & ~prev_carga;
    assign soma_carga = {1'b0, count} + {1'b0, bus.qtd_carga};
    assign soma_lote  = {1'b0, count} + 8'(LOTE_R);
    assign clip_carga = soma_carga > 8'(MAX_R);
    assign clip_lote  = soma_lote > 8'(MAX_R);
    assign ro         = count == 7'd0;
    assign baixo      = count < 7'(MIN_R);
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            estado <= IDLE;
            espera <= '0;
        end else begin
            estado <= estado_nx;
            espera <= espera_nx;
        end
    end
    always_comb begin
        estado_nx = IDLE;
        espera_nx = espera;
        count_nx  = count;
        unique case (estado)
            IDLE: if (bus.enable) begin
                if (pend_consumo != 2'd0) estado_nx = CONSUMO;
                else if (pend_carga) estado_nx = CARGA;
                else if (baixo) begin
                    estado_nx = REPOSICAO;
                    espera_nx = WW'(ESPERA_R - 1);
                end
            end
            CONSUMO: count_nx = ro ? count : count - 7'd1;
            CARGA: count_nx = clip_carga ? 7'(MAX_R) : soma_carga[6:0];
            // dropping enable mid-refill falls back to IDLE with the stock untouched
            REPOSICAO: if (bus.enable && espera != '0) begin
                estado_nx = REPOSICAO;
                espera_nx = espera - 1'b1;
            end else if (bus.enable) count_nx = clip_lote ? 7'(MAX_R) : soma_lote[6:0];
        endcase
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count        <= '0;
            pend_consumo <= '0;
            pend_carga   <= 1'b0;
            prev_consumo <= 1'b0;
            prev_carga   <= 1'b0;
        end else begin
            count        <= count_nx;
            prev_consumo <= bus.req_consumo;
            prev_carga   <= bus.req_carga;
            pend_consumo <= !bus.enable ? 2'd0 :
                            (ed_consumo && estado != CONSUMO) ? (pend_consumo == 2'd3 ? 2'd3 : pend_consumo + 2'd1) :
                            (!ed_consumo && estado == CONSUMO && pend_consumo != 2'd0) ? pend_consumo - 2'd1 :
                            pend_consumo;
            pend_carga   <= bus.enable && (ed_carga || (pend_carga && estado != CARGA));
        end
    end
    assign bus.count         = count;
    assign bus.estado        = estado;
    assign bus.gnt_consumo   = estado == CONSUMO;
    assign bus.gnt_carga     = estado == CARGA;
    assign bus.gnt_reposicao = estado == REPOSICAO;
    assign bus.ro            = ro;
    assign bus.min_r         = baixo;
    assign bus.sat           = (estado == CARGA && clip_carga) || (estado == REPOSICAO && espera == '0 && bus.enable && clip_lote);
    assign bus.falta         = estado == CONSUMO && ro;
endmodule
